mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter MAX_WAIT, default 4, maximum consecutive data grants while an instruction request waits.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports i_req input 1, i_addr input AW: instruction-fetch request and address.
REQ-007 SHALL have ports i_gnt output 1, i_rvalid output 1, i_rdata output DW: fetch grant, response valid, read data.
REQ-008 SHALL have ports d_req input 1, d_we input 1, d_addr input AW, d_wdata input DW, d_be input DW/8: data-port request, write enable, address, write data, byte enables.
REQ-009 SHALL have ports d_gnt output 1, d_rvalid output 1, d_rdata output DW: data grant, response/ack valid, read data.
REQ-010 SHALL have ports m_req, m_we output 1; m_addr output AW; m_wdata output DW; m_be output DW/8: shared memory request bus.
REQ-011 SHALL have ports m_gnt input 1, m_rvalid input 1, m_rdata input DW: memory accept, response valid (reads and writes), read data.
REQ-012 SHALL have port err  output 1  sticky spurious-response flag.

Function
REQ-013 SHALL implement states IDLE, ISSUE, WAIT; one memory transaction outstanding at most.
REQ-014 In IDLE with any request, SHALL select owner, assert owner's gnt combinationally that cycle, capture addr/we/wdata/be (i side: we=0, be=all ones), go to ISSUE.
REQ-015 Selection SHALL be: data wins if d_req and (not i_req or wait_cnt < MAX_WAIT); otherwise instruction wins.
REQ-016 wait_cnt SHALL increment on each data grant while i_req is high, clear on instruction grant or any IDLE cycle with i_req low, saturate at MAX_WAIT.
REQ-017 In ISSUE, m_req SHALL be 1 with captured fields held stable until the cycle m_gnt=1; then go to WAIT.
REQ-018 m_req SHALL be 0 in IDLE and WAIT; m_addr/m_wdata/m_be/m_we SHALL show captured values in all states.
REQ-019 In WAIT, when m_rvalid=1, owner's rvalid SHALL be 1 that cycle with rdata=m_rdata (combinational pass-through); next state IDLE.
REQ-020 Non-owner rvalid SHALL be 0; both rdata outputs SHALL be m_rdata.
REQ-021 No grant SHALL be issued in the cycle m_rvalid completes a transaction; earliest next grant is the following IDLE cycle.
REQ-022 Minimum latency: req in IDLE cycle 0 -> m_req cycle 1 -> with m_gnt cycle 1 and m_rvalid cycle 2, rvalid cycle 2.
REQ-023 Requesters SHALL hold req and fields until gnt; a req dropped before gnt is never served.
REQ-024 m_rvalid while not in WAIT SHALL be ignored for rvalid outputs and SHALL set err, which stays 1 until reset.
REQ-025 m_gnt outside ISSUE SHALL be ignored.

Reset
REQ-026 RST low SHALL immediately force IDLE, wait_cnt=0, err=0, captured fields=0, all gnt/rvalid/m_req=0.
REQ-027 Reset mid-transaction SHALL abandon it; no rvalid for it is generated; a late m_rvalid after reset sets err.
REQ-028 First grant SHALL occur no earlier than the first rising edge after RST returns high.

Verification
REQ-029 Single read: d_req, d_addr=0x10, memory m_gnt immediately, m_rvalid next cycle with 0xDEADBEEF -> d_gnt cycle 0, m_req cycle 1, d_rvalid=1, d_rdata=0xDEADBEEF cycle 2.
REQ-030 Simultaneous i_req and d_req each IDLE, MAX_WAIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-031 Write d_we=1, d_be=4'b0011, d_wdata=0x12345678; m_gnt delayed 3 cycles -> m_req high 4 cycles, fields stable, d_rvalid on m_rvalid.
REQ-032 RST low during WAIT, then m_rvalid=1 after release -> no i_rvalid/d_rvalid, err=1, state IDLE.
REQ-033 m_rvalid pulsed in IDLE -> err=1 and stays 1 through subsequent normal transactions.
REQ-034 Fetch stream only, i_addr incrementing by 4, zero-wait memory -> one i_rvalid every 3 cycles, in address order.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single memory bus with one outstanding transaction.
// Data has priority, but an instruction fetch is served after at most MAX_WAIT data grants.
module mem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_be,
  input  logic            m_gnt,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata,
  output logic            err
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] MaxWait = CW'(MAX_WAIT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;  // 1: data port owns the transaction
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [BW-1:0]   be_q, be_d;
  logic            we_q, we_d;
  logic            err_q, err_d;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    we_d     = we_q;
    err_d    = err_q | (m_rvalid && (state_q != StWait));
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    m_req    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!i_req) cnt_d = '0;
        // Gate with RST so no grant is shown while reset is asserted.
        if (RST && (i_req || d_req)) begin
          state_d = StIssue;
          if (d_req && (!i_req || (cnt_q < MaxWait))) begin
            d_gnt   = 1'b1;
            owner_d = 1'b1;
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
            be_d    = d_be;
            if (i_req) cnt_d = cnt_q + CW'(1);
          end else begin
            i_gnt   = 1'b1;
            owner_d = 1'b0;
            addr_d  = i_addr;
            we_d    = 1'b0;
            wdata_d = '0;
            be_d    = '1;
            cnt_d   = '0;
          end
        end
      end
      StIssue: begin
        m_req = 1'b1;
        if (m_gnt) state_d = StWait;
      end
      StWait: begin
        if (m_rvalid) begin
          i_rvalid = !owner_q;
          d_rvalid = owner_q;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign m_be    = be_q;
  assign m_we    = we_q;
  assign err     = err_q;

endmodule
